// File: rtl/keccak_pkg.sv
// Shared Keccak constants, state layout and squeeze FSM encoding.
package keccak_pkg;

  localparam int ROW_SIZE       = 5;
  localparam int COL_SIZE       = 5;
  localparam int LANE_SIZE      = 64;
  localparam int MAX_RATE_LANES = 21;
  localparam int OUT_LEN_W      = 16;

  localparam int RATE_SHA3_224  = 18;
  localparam int RATE_SHA3_256  = 17;
  localparam int RATE_SHA3_384  = 13;
  localparam int RATE_SHA3_512  = 9;
  localparam int RATE_SHAKE128  = 21;
  localparam int RATE_SHAKE256  = 17;

  // Packed so that the flat port vector maps to [x][y][z] with x outermost.
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

  typedef enum logic [2:0] {
    SQ_IDLE       = 3'd0,
    SQ_WAIT_STATE = 3'd1,
    SQ_EMIT       = 3'd2,
    SQ_REQ_PERM   = 3'd3,
    SQ_DONE       = 3'd4
  } squeeze_state_t;

endpackage

// File: rtl/keccak_squeeze_unit_if.sv
// Control, state-input and lane-output signals of the squeeze unit.
interface keccak_squeeze_unit_if #(
  parameter int OUT_LEN_W = 16
);
  import keccak_pkg::*;

  logic                                       start_i;
  logic [4:0]                                 rate_lanes_i;
  logic [OUT_LEN_W-1:0]                       out_lanes_i;
  logic                                       state_valid_i;
  logic [ROW_SIZE*COL_SIZE*LANE_SIZE-1:0]     state_array_i;
  logic                                       state_ready_o;
  logic                                       perm_req_o;
  logic [LANE_SIZE-1:0]                       dout_o;
  logic                                       dout_valid_o;
  logic                                       dout_ready_i;
  logic                                       dout_last_o;
  logic                                       busy_o;
  logic                                       done_o;
  squeeze_state_t                             state_dbg_o;

  // Both streams are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the source holds data stable until then.
  modport slave (
    input  start_i, rate_lanes_i, out_lanes_i, state_valid_i, state_array_i,
           dout_ready_i,
    output state_ready_o, perm_req_o, dout_o, dout_valid_o, dout_last_o,
           busy_o, done_o, state_dbg_o
  );

  modport master (
    output start_i, rate_lanes_i, out_lanes_i, state_valid_i, state_array_i,
           dout_ready_i,
    input  state_ready_o, perm_req_o, dout_o, dout_valid_o, dout_last_o,
           busy_o, done_o, state_dbg_o
  );

endinterface

// File: rtl/keccak_lane_sel.sv
// Combinational 25:1 lane selector addressed by (x, y).
module keccak_lane_sel
  import keccak_pkg::*;
(
  input  state_t               i_state,
  input  logic [2:0]           i_x,
  input  logic [2:0]           i_y,
  output logic [LANE_SIZE-1:0] o_lane
);

  always_comb begin
    o_lane = '0;
    for (int x = 0; x < ROW_SIZE; x++) begin
      for (int y = 0; y < COL_SIZE; y++) begin
        if (i_x == 3'(x) && i_y == 3'(y)) o_lane = i_state[x][y];
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Squeeze stage: holds a permuted state and streams its rate lanes, asking
// for further permutations when more output than one rate block is needed.
module keccak_squeeze_unit #(
  parameter int MAX_RATE_LANES = keccak_pkg::MAX_RATE_LANES,
  parameter int OUT_LEN_W      = keccak_pkg::OUT_LEN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  keccak_squeeze_unit_if.slave bus
);
  import keccak_pkg::*;

  squeeze_state_t       r_fsm, w_fsm_nxt;
  state_t               r_state_q;
  state_t               w_state_in;
  logic [4:0]           r_rate;
  logic [4:0]           r_idx;
  logic [2:0]           r_x, r_y;
  logic [OUT_LEN_W-1:0] r_remaining;
  logic [4:0]           w_rate_sat;
  logic [LANE_SIZE-1:0] w_lane;
  logic                 w_emit;
  logic                 w_hs;

  assign w_state_in = bus.state_array_i;
  assign w_emit     = (r_fsm == SQ_EMIT);
  assign w_hs       = w_emit && bus.dout_ready_i;

  always_comb begin
    w_rate_sat = bus.rate_lanes_i;
    if (bus.rate_lanes_i == 5'd0)                        w_rate_sat = 5'd1;
    else if (bus.rate_lanes_i > 5'(MAX_RATE_LANES))      w_rate_sat = 5'(MAX_RATE_LANES);
  end

  keccak_lane_sel u_lane_sel (
    .i_state (r_state_q),
    .i_x     (r_x),
    .i_y     (r_y),
    .o_lane  (w_lane)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      SQ_IDLE: begin
        if (bus.start_i) w_fsm_nxt = (bus.out_lanes_i == '0) ? SQ_DONE : SQ_WAIT_STATE;
      end
      SQ_WAIT_STATE: if (bus.state_valid_i) w_fsm_nxt = SQ_EMIT;
      SQ_EMIT: begin
        if (bus.dout_ready_i) begin
          if (r_remaining == OUT_LEN_W'(1))  w_fsm_nxt = SQ_DONE;
          else if (r_idx == r_rate - 5'd1)   w_fsm_nxt = SQ_REQ_PERM;
        end
      end
      SQ_REQ_PERM: w_fsm_nxt = SQ_WAIT_STATE;
      SQ_DONE:     w_fsm_nxt = SQ_IDLE;
      default:     w_fsm_nxt = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm       <= SQ_IDLE;
      r_state_q   <= '0;
      r_rate      <= '0;
      r_idx       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_remaining <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == SQ_IDLE && bus.start_i) begin
        r_rate      <= w_rate_sat;
        r_remaining <= bus.out_lanes_i;
      end
      if (r_fsm == SQ_WAIT_STATE && bus.state_valid_i) begin
        r_state_q <= w_state_in;
        r_idx     <= '0;
        r_x       <= '0;
        r_y       <= '0;
      end
      // x/y track idx as (idx mod 5, idx / 5) without a divider.
      if (w_hs) begin
        r_remaining <= r_remaining - OUT_LEN_W'(1);
        r_idx       <= r_idx + 5'd1;
        if (r_x == 3'd4) begin
          r_x <= '0;
          r_y <= r_y + 3'd1;
        end else begin
          r_x <= r_x + 3'd1;
        end
      end
    end
  end

  assign bus.state_ready_o = (r_fsm == SQ_WAIT_STATE);
  assign bus.perm_req_o    = (r_fsm == SQ_REQ_PERM);
  assign bus.dout_valid_o  = w_emit;
  assign bus.dout_o        = w_emit ? w_lane : '0;
  assign bus.dout_last_o   = w_emit && (r_remaining == OUT_LEN_W'(1));
  assign bus.busy_o        = (r_fsm != SQ_IDLE);
  assign bus.done_o        = (r_fsm == SQ_DONE);
  assign bus.state_dbg_o   = r_fsm;

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Directed bench for keccak_squeeze_unit: digests, row wrap, SHAKE
// extension, backpressure, zero length, ignored inputs and async reset.
module tb_keccak_squeeze_unit;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [63:0] BASE_A = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] BASE_B = 64'hBEEF_0000_0000_0000;
  localparam logic [63:0] BASE_C = 64'hC0DE_0000_0000_0000;
  localparam logic [63:0] BASE_X = 64'hDEAD_0000_0000_0000;

  always #5 clk = ~clk;

  keccak_squeeze_unit_if #(.OUT_LEN_W(16)) bus ();

  keccak_squeeze_unit #(.MAX_RATE_LANES(21), .OUT_LEN_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic state_t mk_state(input logic [63:0] base);
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = base | 64'(5 * y + x);
    return s;
  endfunction

  task automatic do_start(input logic [4:0] rate, input logic [15:0] len);
    bus.start_i      = 1'b1;
    bus.rate_lanes_i = rate;
    bus.out_lanes_i  = len;
    step();
    bus.start_i      = 1'b0;
  endtask

  task automatic feed(input string tag, input logic [63:0] base);
    chk({tag, "_ready"}, 64'(bus.state_ready_o), 64'd1);
    bus.state_valid_i = 1'b1;
    bus.state_array_i = mk_state(base);
    step();
    bus.state_valid_i = 1'b0;
  endtask

  // One accepted lane: checks the presented beat, then clocks the handshake.
  task automatic beat(input string tag, input logic [63:0] exp_data, input logic exp_last);
    chk({tag, "_valid"}, 64'(bus.dout_valid_o), 64'd1);
    chk({tag, "_data"},  bus.dout_o,            exp_data);
    chk({tag, "_last"},  64'(bus.dout_last_o),  64'(exp_last));
    chk({tag, "_perm"},  64'(bus.perm_req_o),   64'd0);
    step();
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"},  64'(bus.done_o),       64'd1);
    chk({tag, "_dval"},  64'(bus.dout_valid_o), 64'd0);
    step();
    chk({tag, "_done_off"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_idle"},     64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.rate_lanes_i  = '0;
    bus.out_lanes_i   = '0;
    bus.state_valid_i = 1'b0;
    bus.state_array_i = '0;
    bus.dout_ready_i  = 1'b1;

    // Reset state
    #2;
    chk("rst_busy",  64'(bus.busy_o),        64'd0);
    chk("rst_ready", 64'(bus.state_ready_o), 64'd0);
    chk("rst_valid", 64'(bus.dout_valid_o),  64'd0);
    chk("rst_dout",  bus.dout_o,             64'd0);
    chk("rst_fsm",   64'(bus.state_dbg_o),   64'(SQ_IDLE));
    step();
    rst_n = 1'b1;
    step();

    // SHA3-256 four-lane digest
    do_start(5'd17, 16'd4);
    chk("s256_busy", 64'(bus.busy_o), 64'd1);
    feed("s256", BASE_A);
    for (int k = 0; k < 4; k++)
      beat($sformatf("s256_b%0d", k), BASE_A | 64'(k), k == 3);
    expect_done("s256");

    // Row wrap; stray state_valid and start during EMIT must be ignored
    do_start(5'd17, 16'd7);
    feed("wrap", BASE_A);
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        bus.state_valid_i = 1'b1;
        bus.state_array_i = mk_state(BASE_X);
        bus.start_i       = 1'b1;
        bus.out_lanes_i   = 16'd0;
      end
      beat($sformatf("wrap_b%0d", k), BASE_A | 64'(k), k == 6);
      bus.state_valid_i = 1'b0;
      bus.start_i       = 1'b0;
    end
    expect_done("wrap");

    // SHAKE128: 21 lanes, one permutation request, then 2 more lanes
    do_start(5'd21, 16'd23);
    feed("shk", BASE_A);
    for (int k = 0; k < 21; k++)
      beat($sformatf("shk_b%0d", k), BASE_A | 64'(k), 1'b0);
    chk("shk_perm_hi",  64'(bus.perm_req_o),    64'd1);
    chk("shk_rdy_lo",   64'(bus.state_ready_o), 64'd0);
    chk("shk_val_lo",   64'(bus.dout_valid_o),  64'd0);
    step();
    chk("shk_perm_lo",  64'(bus.perm_req_o),    64'd0);
    feed("shk2", BASE_B);
    beat("shk_b21", BASE_B | 64'd0, 1'b0);
    beat("shk_b22", BASE_B | 64'd1, 1'b1);
    expect_done("shk");

    // Rate above the maximum saturates to 21 lanes per block
    do_start(5'd31, 16'd22);
    feed("sat", BASE_C);
    for (int k = 0; k < 21; k++)
      beat($sformatf("sat_b%0d", k), BASE_C | 64'(k), 1'b0);
    chk("sat_perm", 64'(bus.perm_req_o), 64'd1);
    step();
    feed("sat2", BASE_B);
    beat("sat_b21", BASE_B | 64'd0, 1'b1);
    expect_done("sat");

    // Rate 0 becomes 1: a permutation after every lane
    do_start(5'd0, 16'd2);
    feed("r0", BASE_A);
    beat("r0_b0", BASE_A | 64'd0, 1'b0);
    chk("r0_perm", 64'(bus.perm_req_o), 64'd1);
    step();
    feed("r0b", BASE_B);
    beat("r0_b1", BASE_B | 64'd0, 1'b1);
    expect_done("r0");

    // Backpressure: three stalled cycles on lane 2
    do_start(5'd17, 16'd6);
    feed("bp", BASE_C);
    beat("bp_b0", BASE_C | 64'd0, 1'b0);
    beat("bp_b1", BASE_C | 64'd1, 1'b0);
    bus.dout_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), 64'(bus.dout_valid_o), 64'd1);
      chk($sformatf("bp_hold%0d_data", k),  bus.dout_o,            BASE_C | 64'd2);
      chk($sformatf("bp_hold%0d_last", k),  64'(bus.dout_last_o),  64'd0);
      step();
    end
    bus.dout_ready_i = 1'b1;
    for (int k = 2; k < 6; k++)
      beat($sformatf("bp_b%0d", k), BASE_C | 64'(k), k == 5);
    expect_done("bp");

    // Zero-length squeeze
    do_start(5'd17, 16'd0);
    chk("zero_ready", 64'(bus.state_ready_o), 64'd0);
    expect_done("zero");

    // Async reset in the middle of a squeeze
    do_start(5'd17, 16'd5);
    feed("rst", BASE_A);
    beat("rst_b0", BASE_A | 64'd0, 1'b0);
    beat("rst_b1", BASE_A | 64'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.dout_valid_o),  64'd0);
    chk("mid_rst_dout",  bus.dout_o,             64'd0);
    chk("mid_rst_busy",  64'(bus.busy_o),        64'd0);
    chk("mid_rst_done",  64'(bus.done_o),        64'd0);
    chk("mid_rst_last",  64'(bus.dout_last_o),   64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst_done%0d", k), 64'(bus.done_o), 64'd0);
      chk($sformatf("post_rst_busy%0d", k), 64'(bus.busy_o), 64'd0);
      step();
    end
    do_start(5'd17, 16'd3);
    feed("again", BASE_C);
    for (int k = 0; k < 3; k++)
      beat($sformatf("again_b%0d", k), BASE_C | 64'(k), k == 2);
    expect_done("again");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/keccak_squeeze_unit.md
Name: keccak_squeeze_unit

Overview:
Sequential output stage of the Keccak sponge. It captures a 1600-bit permuted state and streams the rate portion as 64-bit lanes over a valid/ready interface. When more output is required than one rate block holds (SHAKE extendable output), it requests further permutations. It sits between the permutation core (round steps theta..iota) and the digest consumer; it is the reader counterpart to the absorb path that writes the state.

Parameters:
MAX_RATE_LANES, 21, largest legal rate in lanes (SHAKE128); larger requests saturate to this value.
OUT_LEN_W, 16, width of the requested-output-length counter in lanes.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start a squeeze; sampled only in IDLE
rate_lanes_i  in  5  rate in lanes (SHA3-256=17, SHA3-512=9, SHAKE128=21); sampled with start_i
out_lanes_i  in  OUT_LEN_W  total lanes to emit; sampled with start_i
state_valid_i  in  1  permuted state available
state_array_i  in  ROW_SIZE*COL_SIZE*LANE_SIZE  state, indexed [x][y][z]
state_ready_o  out  1  unit accepts a state this cycle
perm_req_o  out  1  one-cycle pulse: run another permutation on the held state
dout_o  out  LANE_SIZE  output lane
dout_valid_o  out  1  dout_o valid
dout_ready_i  in  1  consumer accepts dout_o
dout_last_o  out  1  marks final lane of the squeeze
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE, state register, counters, and all outputs 0.
- FSM states: IDLE, WAIT_STATE, EMIT, REQ_PERM, DONE.
- IDLE: on start_i, latch rate (0 becomes 1; values above MAX_RATE_LANES become MAX_RATE_LANES) and remaining=out_lanes_i. If out_lanes_i==0, go to DONE; otherwise go to WAIT_STATE.
- WAIT_STATE: state_ready_o=1. On state_valid_i, register the full state, clear the lane counters, and go to EMIT.
- EMIT:
  - dout_valid_o=1; dout_o = state_q[x_q][y_q].
  - Lane index i maps to x=i mod 5, y=i/5. This is tracked with x_q/y_q counters; x wraps from 4 to 0 and increments y. No divider.
  - dout_o, dout_valid_o and dout_last_o hold stable while dout_ready_i=0.
  - dout_last_o=1 when remaining==1.
  - On a handshake: remaining decrements and the lane index advances.
  - If remaining was 1, go to DONE.
  - Else if the lane index was rate-1, go to REQ_PERM.
  - Else stay in EMIT.
- REQ_PERM: perm_req_o=1 for exactly one cycle, then go to WAIT_STATE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Latency:
  - start_i to state_ready_o: 1 cycle.
  - State capture to first dout_valid_o: 1 cycle.
  - Throughput: 1 lane/cycle with dout_ready_i tied high.
- start_i is ignored while busy_o=1.
- state_valid_i outside WAIT_STATE is ignored; the state is not captured.
- Lanes beyond the rate (capacity) are never output.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done_o pulse is produced for the aborted squeeze.

Decomposition:
- keccak_pkg:
  - ROW_SIZE, COL_SIZE, LANE_SIZE (existing).
  - New MAX_RATE_LANES constant.
  - Rate constants RATE_SHA3_224=18, RATE_SHA3_256=17, RATE_SHA3_384=13, RATE_SHA3_512=9, RATE_SHAKE128=21, RATE_SHAKE256=17.
  - Enum squeeze_state_t for the FSM.
- Optional sub-module keccak_lane_sel: a combinational 25:1 lane mux indexed by (x,y), reusable by the absorb path.

Test Plan:
- SHA3-256 digest:
  - Stimulus: state lane[x][y] = 64'hA5A5_0000_0000_0000 | (5y+x); rate=17; out_lanes=4; dout_ready_i=1.
  - Response: dout_o = ...00, ...01, ...02, ...03 on consecutive cycles; dout_last_o only on the 4th; done_o pulses once; perm_req_o never asserts.
- Row wrap:
  - Stimulus: rate=17, out_lanes=7.
  - Response: 6th lane = state[0][1] (value ...05); 7th lane = state[1][1] (...06).
- SHAKE128 extension:
  - Stimulus: rate=21, out_lanes=23.
  - Response: 21 lanes ...00–...14; then a single-cycle perm_req_o and state_ready_o high again. Feed a second state with lane = 64'hBEEF_0000_0000_0000 | i: output ...BEEF..00 and ...BEEF..01, with last on the 23rd beat.
- Backpressure:
  - Stimulus: drop dout_ready_i for 3 cycles mid-stream.
  - Response: dout_o and dout_valid_o held unchanged; no lane skipped or duplicated.
- Zero length and start while busy:
  - Stimulus: out_lanes=0.
  - Response: done_o the cycle after IDLE exits; no dout_valid_o or state_ready_o.
  - Stimulus: start_i pulsed during EMIT.
  - Response: no effect.
- Reset mid-EMIT:
  - Stimulus: assert rst_ni=0 asynchronously after 2 lanes.
  - Response: all outputs 0 immediately; no done_o. A following start runs cleanly from lane 0.
